gate_model_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the 23-input / 10-output combinational gate models in the simulator gate library. It generates pseudo-random input vectors with an LFSR, drives them into the gate model, and waits a programmable settle time. It then compacts the model outputs into a 16-bit MISR signature and flags pass/fail against a golden signature. It sits between the lab test harness (start/abort/result) and one gate-model instance.

---
 rtl/gate_model_bist_ctrl.sv | 147 ++++++++++++++
 tb/tb_gate_model_bist_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_model_bist_ctrl.sv
// BIST sequencer for combinational gate models: LFSR vectors in,
// settle, MISR-compact outputs, compare against a golden signature.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start       : begin a run (accepted in IDLE or DONE)
//   abort       : end the run and return to IDLE (wins over start)
//   golden_sig  : expected signature, latched when start is accepted
//   dut_out     : gate-model outputs, sampled in the CAPTURE cycle
//   dut_in      : gate-model inputs (current LFSR value)
//   busy        : run in progress (APPLY/CAPTURE)
//   done        : run complete
//   pass        : signature matched golden (valid while done)
//   signature   : MISR contents
//   pat_cnt     : vectors captured so far
module gate_model_bist_ctrl #(
    parameter int              N_IN     = 23,
    parameter int              N_OUT    = 10,
    parameter int              PATTERNS = 1024,
    parameter int              SETTLE   = 2,
    parameter logic [N_IN-1:0] SEED     = 23'h000001,
    parameter logic [N_IN-1:0] TAPS     = 23'h420000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [15:0]                       golden_sig,
    input  logic [N_OUT-1:0]                  dut_out,
    output logic [N_IN-1:0]                   dut_in,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [15:0]                       signature,
    output logic [$clog2(PATTERNS+1)-1:0]     pat_cnt
);

    localparam int PW = $clog2(PATTERNS + 1);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0] SEED_EFF =
        (SEED == '0) ? N_IN'(1) : SEED;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CAPTURE,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [N_IN-1:0] lfsr;
    logic [15:0]     misr;
    logic [PW-1:0]   cnt;
    logic [SW-1:0]   settle_cnt;
    logic [15:0]     golden;
    logic            pass_q;

    logic [N_IN-1:0] lfsr_nxt;
    logic [15:0]     misr_nxt;
    logic [PW-1:0]   cnt_nxt;
    logic            last_settle;
    logic            last_pat;
    logic            start_ok;

    assign lfsr_nxt    = {lfsr[N_IN-2:0], ^(lfsr & TAPS)};
    assign misr_nxt    = {misr[14:0], ^(misr & 16'hB400)}
                       ^ 16'(dut_out);
    assign cnt_nxt     = cnt + PW'(1);
    assign last_settle = (settle_cnt == SW'(SETTLE - 1));
    assign last_pat    = (cnt_nxt == PW'(PATTERNS));
    assign start_ok    = start && !abort
                       && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) state_nxt = APPLY;
                end
                APPLY: begin
                    if (last_settle) state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    state_nxt = last_pat ? DONE : APPLY;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        busy      = (state == APPLY) || (state == CAPTURE);
        done      = (state == DONE);
        pass      = pass_q;
        dut_in    = lfsr;
        signature = misr;
        pat_cnt   = cnt;
    end

    // Datapath: abort only clears pass; everything else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr       <= '0;
            misr       <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            golden     <= '0;
            pass_q     <= 1'b0;
        end else if (abort) begin
            pass_q <= 1'b0;
        end else if (start_ok) begin
            lfsr       <= SEED_EFF;
            misr       <= '0;
            cnt        <= '0;
            settle_cnt <= '0;
            golden     <= golden_sig;
            pass_q     <= 1'b0;
        end else if (state == APPLY) begin
            settle_cnt <= settle_cnt + SW'(1);
        end else if (state == CAPTURE) begin
            misr       <= misr_nxt;
            lfsr       <= lfsr_nxt;
            cnt        <= cnt_nxt;
            settle_cnt <= '0;
            if (last_pat) pass_q <= (misr_nxt == golden);
        end
    end

endmodule

// File: tb/tb_gate_model_bist_ctrl.sv
// Bench for gate_model_bist_ctrl: three instances (4x1, 2x1 and
// default 1024x2) checked against a behavioural signature model.
module tb_gate_model_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // small: PATTERNS=4, SETTLE=1
    logic        st_s = 0, ab_s = 0;
    logic [15:0] gold_s = 0;
    logic [9:0]  out_s = 0;
    logic [22:0] in_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] sig_s;
    logic [2:0]  cnt_s;

    // two: PATTERNS=2, SETTLE=1
    logic        st_t = 0, ab_t = 0;
    logic [15:0] gold_t = 0;
    logic [9:0]  out_t = 0;
    logic [22:0] in_t;
    logic        busy_t, done_t, pass_t;
    logic [15:0] sig_t;
    logic [1:0]  cnt_t;

    // full: defaults, driven by the behavioural gate model
    logic        st_f = 0, ab_f = 0;
    logic [15:0] gold_f = 0;
    logic [9:0]  out_f;
    logic [22:0] in_f;
    logic        busy_f, done_f, pass_f;
    logic [15:0] sig_f;
    logic [10:0] cnt_f;

    function automatic logic [9:0] gate(input logic [22:0] v);
        return v[9:0] ^ v[22:13] ^ (v[19:10] & v[12:3]);
    endfunction

    assign out_f = gate(in_f);

    gate_model_bist_ctrl #(.PATTERNS(4), .SETTLE(1)) u_small (
        .clk(clk), .rst(rst), .start(st_s), .abort(ab_s),
        .golden_sig(gold_s), .dut_out(out_s), .dut_in(in_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .signature(sig_s), .pat_cnt(cnt_s)
    );

    gate_model_bist_ctrl #(.PATTERNS(2), .SETTLE(1)) u_two (
        .clk(clk), .rst(rst), .start(st_t), .abort(ab_t),
        .golden_sig(gold_t), .dut_out(out_t), .dut_in(in_t),
        .busy(busy_t), .done(done_t), .pass(pass_t),
        .signature(sig_t), .pat_cnt(cnt_t)
    );

    gate_model_bist_ctrl u_full (
        .clk(clk), .rst(rst), .start(st_f), .abort(ab_f),
        .golden_sig(gold_f), .dut_out(out_f), .dut_in(in_f),
        .busy(busy_f), .done(done_f), .pass(pass_f),
        .signature(sig_f), .pat_cnt(cnt_f)
    );

    // Reference: walk n vectors from seed 1, folding each output
    // into the signature polynomial using population-count parity.
    function automatic logic [15:0] ref_sig(input int n,
                                            input bit use_gate,
                                            input logic [9:0] c);
        logic [22:0] v;
        logic [15:0] m;
        logic [9:0]  o;
        int          fb;
        v = 23'h000001;
        m = 16'h0000;
        for (int i = 0; i < n; i++) begin
            o  = use_gate ? gate(v) : c;
            fb = $countones(m & 16'hB400) % 2;
            m  = ((m << 1) | 16'(fb)) ^ 16'(o);
            fb = $countones(v & 23'h420000) % 2;
            v  = (v << 1) | 23'(fb);
        end
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_small(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (done_s) break;
        end
    endtask

    task automatic wait_two(output int n);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (done_t) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks += 3;
        if ({in_s, busy_s, done_s, pass_s, sig_s, cnt_s} !== '0) begin
            errors++;
            $display("FAIL reset_small: got in=%h b=%b d=%b p=%b sig=%h cnt=%0d want all zero",
                     in_s, busy_s, done_s, pass_s, sig_s, cnt_s);
        end
        if ({in_t, busy_t, done_t, pass_t, sig_t, cnt_t} !== '0) begin
            errors++;
            $display("FAIL reset_two: got in=%h b=%b d=%b p=%b sig=%h cnt=%0d want all zero",
                     in_t, busy_t, done_t, pass_t, sig_t, cnt_t);
        end
        if ({in_f, busy_f, done_f, pass_f, sig_f, cnt_f} !== '0) begin
            errors++;
            $display("FAIL reset_full: got in=%h b=%b d=%b p=%b sig=%h cnt=%0d want all zero",
                     in_f, busy_f, done_f, pass_f, sig_f, cnt_f);
        end
    endtask

    task automatic test_zero_run();
        int n;
        out_s = 10'h000;
        gold_s = 16'h0000;
        st_s = 1'b1;
        tick();
        st_s = 1'b0;
        checks++;
        if (busy_s !== 1'b1 || in_s !== 23'h000001) begin
            errors++;
            $display("FAIL zero_start: got busy=%b in=%h want busy=1 in=000001",
                     busy_s, in_s);
        end
        wait_small(n);
        checks += 2;
        if (n != 8) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles want 8", n);
        end
        if (pass_s !== 1'b1 || sig_s !== 16'h0000 || cnt_s !== 3'd4) begin
            errors++;
            $display("FAIL zero_result: got pass=%b sig=%h cnt=%0d want 1 0000 4",
                     pass_s, sig_s, cnt_s);
        end
    endtask

    task automatic test_two_vec(input logic [15:0] g,
                                input logic exp_pass);
        out_t = 10'h001;
        gold_t = g;
        st_t = 1'b1;
        tick();
        st_t = 1'b0;
        checks++;
        if (in_t !== 23'h000001 || sig_t !== 16'h0000) begin
            errors++;
            $display("FAIL two_first: got in=%h sig=%h want 000001 0000",
                     in_t, sig_t);
        end
        tick();
        checks++;
        if (in_t !== 23'h000001) begin
            errors++;
            $display("FAIL two_hold: got in=%h want 000001", in_t);
        end
        tick();
        checks++;
        if (in_t !== 23'h000002 || sig_t !== 16'h0001 || cnt_t !== 2'd1) begin
            errors++;
            $display("FAIL two_cap1: got in=%h sig=%h cnt=%0d want 000002 0001 1",
                     in_t, sig_t, cnt_t);
        end
        tick();
        tick();
        checks++;
        if (done_t !== 1'b1 || sig_t !== 16'h0003 || pass_t !== exp_pass) begin
            errors++;
            $display("FAIL two_done: got done=%b sig=%h pass=%b want 1 0003 %b",
                     done_t, sig_t, pass_t, exp_pass);
        end
    endtask

    task automatic test_random_two();
        logic [9:0]  c;
        logic [15:0] e;
        logic [15:0] g;
        int          n;
        for (int i = 0; i < 6; i++) begin
            c = 10'($urandom);
            e = ref_sig(2, 1'b0, c);
            g = (i % 2 == 0) ? e : 16'($urandom);
            out_t = c;
            gold_t = g;
            st_t = 1'b1;
            tick();
            st_t = 1'b0;
            wait_two(n);
            checks++;
            if (n != 4 || sig_t !== e || pass_t !== (g == e)) begin
                errors++;
                $display("FAIL rand_two: got n=%0d sig=%h pass=%b want 4 %h %b",
                         n, sig_t, pass_t, e, (g == e));
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [9:0]  c;
        logic [15:0] e;
        int          n;
        c = 10'($urandom);
        e = ref_sig(4, 1'b0, c);
        out_s = c;
        gold_s = e;
        st_s = 1'b1;
        tick();
        st_s = 1'b0;
        repeat (4) tick();
        checks++;
        if (busy_s !== 1'b1 || cnt_s !== 3'd2) begin
            errors++;
            $display("FAIL rst_mid_pos: got busy=%b cnt=%0d want 1 2",
                     busy_s, cnt_s);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({in_s, busy_s, done_s, pass_s, sig_s, cnt_s} !== '0) begin
            errors++;
            $display("FAIL rst_mid_clear: got in=%h b=%b d=%b p=%b sig=%h cnt=%0d want all zero",
                     in_s, busy_s, done_s, pass_s, sig_s, cnt_s);
        end
        st_s = 1'b1;
        tick();
        st_s = 1'b0;
        wait_small(n);
        checks++;
        if (n != 8 || sig_s !== e || pass_s !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_rerun: got n=%0d sig=%h pass=%b want 8 %h 1",
                     n, sig_s, pass_s, e);
        end
    endtask

    task automatic test_abort();
        logic [9:0]  c;
        logic [15:0] e;
        logic [15:0] hs;
        logic [15:0] ssig;
        logic [2:0]  scnt;
        int          n;
        hs = sig_s;
        ab_s = 1'b1;
        tick();
        ab_s = 1'b0;
        checks++;
        if (done_s !== 1'b0 || pass_s !== 1'b0 || sig_s !== hs) begin
            errors++;
            $display("FAIL abort_done: got done=%b pass=%b sig=%h want 0 0 %h",
                     done_s, pass_s, sig_s, hs);
        end
        ab_s = 1'b1;
        st_s = 1'b1;
        tick();
        ab_s = 1'b0;
        st_s = 1'b0;
        tick();
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL abort_with_start: got busy=%b done=%b want 0 0",
                     busy_s, done_s);
        end
        c = 10'($urandom);
        e = ref_sig(4, 1'b0, c);
        out_s = c;
        gold_s = e;
        st_s = 1'b1;
        tick();
        st_s = 1'b0;
        repeat (3) tick();
        ssig = sig_s;
        scnt = cnt_s;
        ab_s = 1'b1;
        tick();
        ab_s = 1'b0;
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || sig_s !== ssig
            || cnt_s !== scnt || scnt !== 3'd1) begin
            errors++;
            $display("FAIL abort_mid: got busy=%b done=%b sig=%h cnt=%0d want 0 0 %h 1",
                     busy_s, done_s, sig_s, cnt_s, ssig);
        end
        st_s = 1'b1;
        tick();
        st_s = 1'b0;
        wait_small(n);
        checks++;
        if (n != 8 || sig_s !== e || pass_s !== 1'b1 || cnt_s !== 3'd4) begin
            errors++;
            $display("FAIL abort_rerun: got n=%0d sig=%h pass=%b cnt=%0d want 8 %h 1 4",
                     n, sig_s, pass_s, cnt_s, e);
        end
    endtask

    task automatic test_full();
        logic [15:0] e;
        int          n;
        e = ref_sig(1024, 1'b1, 10'h000);
        gold_f = e;
        st_f = 1'b1;
        tick();
        st_f = 1'b0;
        n = 0;
        while (n < 4000) begin
            tick();
            n++;
            if (n == 10) st_f = 1'b1;
            if (n == 11) st_f = 1'b0;
            if (done_f) break;
        end
        checks += 2;
        if (n != 3072) begin
            errors++;
            $display("FAIL full_latency: got %0d cycles want 3072", n);
        end
        if (sig_f !== e || pass_f !== 1'b1 || cnt_f !== 11'd1024
            || busy_f !== 1'b0) begin
            errors++;
            $display("FAIL full_result: got sig=%h pass=%b cnt=%0d busy=%b want %h 1 1024 0",
                     sig_f, pass_f, cnt_f, busy_f, e);
        end
        gold_f = e ^ 16'h0001;
        st_f = 1'b1;
        tick();
        st_f = 1'b0;
        checks++;
        if (done_f !== 1'b0 || busy_f !== 1'b1 || in_f !== 23'h000001
            || cnt_f !== 11'd0 || sig_f !== 16'h0000) begin
            errors++;
            $display("FAIL full_restart: got done=%b busy=%b in=%h cnt=%0d sig=%h want 0 1 000001 0 0000",
                     done_f, busy_f, in_f, cnt_f, sig_f);
        end
        n = 0;
        while (n < 4000) begin
            tick();
            n++;
            if (done_f) break;
        end
        checks++;
        if (n != 3072 || sig_f !== e || pass_f !== 1'b0) begin
            errors++;
            $display("FAIL full_bad_golden: got n=%0d sig=%h pass=%b want 3072 %h 0",
                     n, sig_f, pass_f, e);
        end
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_two_vec(16'h0003, 1'b1);
        test_two_vec(16'h0004, 1'b0);
        test_random_two();
        test_rst_mid();
        test_abort();
        test_full();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
